// File: rtl/eq2_compare_sequencer_if.sv
// Request/result handshake plus the slice bus to the shared external eq2 comparator.
// The master side is the requester together with the comparator.
interface eq2_compare_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned N    = WIDTH / 2;
    localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       slice_a;
    logic [1:0]       slice_b;
    logic             slice_eq;
    logic             out_valid;
    logic             out_ready;
    logic             out_eq;
    logic [IDXW-1:0]  out_mismatch_idx;
    logic             busy;

    modport master (
        output in_valid, a, b, slice_eq, out_ready,
        input  in_ready, slice_a, slice_b, out_valid, out_eq, out_mismatch_idx, busy
    );

    modport slave (
        input  in_valid, a, b, slice_eq, out_ready,
        output in_ready, slice_a, slice_b, out_valid, out_eq, out_mismatch_idx, busy
    );
endinterface

// File: rtl/eq2_compare_sequencer.sv
// Compares two WIDTH-bit operands one 2-bit slice per cycle (LSB first) through a
// shared external eq2 comparator, reporting overall equality and lowest mismatching slice.
module eq2_compare_sequencer #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    eq2_compare_sequencer_if.slave bus
);
    localparam int unsigned N    = WIDTH / 2;
    localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDXW-1:0]  idx_q;
    logic [IDXW-1:0]  mis_q;
    logic             eq_q;
    logic [1:0]       slice_a_c;
    logic [1:0]       slice_b_c;

    // Slice mux towards the comparator; parked at zero outside RUN.
    always_comb begin
        slice_a_c = 2'b00;
        slice_b_c = 2'b00;
        if (state_q == S_RUN) begin
            slice_a_c = 2'(a_q >> {idx_q, 1'b0});
            slice_b_c = 2'(b_q >> {idx_q, 1'b0});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            mis_q   <= '0;
            eq_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        idx_q   <= '0;
                        eq_q    <= 1'b1;
                        mis_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Only the first (lowest) mismatching slice is recorded.
                    if (!bus.slice_eq && eq_q) begin
                        eq_q  <= 1'b0;
                        mis_q <= idx_q;
                    end
                    if ((!bus.slice_eq && EARLY_EXIT) || (idx_q == LAST_IDX)) begin
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready         = (state_q == S_IDLE);
    assign bus.busy             = (state_q != S_IDLE);
    assign bus.out_valid        = (state_q == S_DONE);
    assign bus.out_eq           = eq_q;
    assign bus.out_mismatch_idx = mis_q;
    assign bus.slice_a          = slice_a_c;
    assign bus.slice_b          = slice_b_c;
endmodule

// File: tb/tb_eq2_compare_sequencer.sv
// Bench for eq2_compare_sequencer: dut 0 has EARLY_EXIT=0, dut 1 has EARLY_EXIT=1,
// each wired to an ideal eq2 comparator.
module tb_eq2_compare_sequencer;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned N     = WIDTH / 2;

    logic       clk;
    logic [1:0] reset_s;
    logic [1:0] in_valid_s;
    logic [1:0] out_ready_s;
    logic [7:0] a_s [2];
    logic [7:0] b_s [2];

    logic [1:0] in_ready_o;
    logic [1:0] busy_o;
    logic [1:0] out_valid_o;
    logic [1:0] out_eq_o;
    logic [1:0] slice_a_o [2];
    logic [1:0] slice_b_o [2];
    logic [1:0] idx_o [2];

    int n_checks;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        eq2_compare_sequencer_if #(.WIDTH(WIDTH)) bus ();

        eq2_compare_sequencer #(.WIDTH(WIDTH), .EARLY_EXIT(1'(g))) dut (
            .clk   (clk),
            .reset (reset_s[g]),
            .bus   (bus)
        );

        assign bus.in_valid  = in_valid_s[g];
        assign bus.a         = a_s[g];
        assign bus.b         = b_s[g];
        assign bus.out_ready = out_ready_s[g];
        assign bus.slice_eq  = (bus.slice_a == bus.slice_b);

        assign in_ready_o[g]  = bus.in_ready;
        assign busy_o[g]      = bus.busy;
        assign out_valid_o[g] = bus.out_valid;
        assign out_eq_o[g]    = bus.out_eq;
        assign slice_a_o[g]   = bus.slice_a;
        assign slice_b_o[g]   = bus.slice_b;
        assign idx_o[g]       = bus.out_mismatch_idx;
    end

    task automatic check(input string name, input int sel, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, sel, act, exp, $time);
        end
    endtask

    // Reference: lowest differing 2-bit slice of a^b decides result and latency.
    function automatic void model(input int ee, input logic [7:0] a, input logic [7:0] b,
                                  output logic eq, output logic [1:0] idx, output int lat);
        logic [7:0] diff;
        diff = a ^ b;
        eq   = 1'b1;
        idx  = 2'd0;
        lat  = N + 1;
        for (int i = N - 1; i >= 0; i--) begin
            if (((diff >> (2 * i)) & 8'h3) != 8'h0) begin
                eq  = 1'b0;
                idx = 2'(i);
                lat = (ee != 0) ? i + 2 : N + 1;
            end
        end
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_txn(input int sel, input logic [7:0] a, input logic [7:0] b,
                           input int delay, input bit hold, input logic [7:0] na,
                           input logic [7:0] nb, input logic exp_eq,
                           input logic [1:0] exp_idx, input int exp_lat);
        check("in_ready_idle", sel, 32'(in_ready_o[sel]), 32'd1);
        in_valid_s[sel]  = 1'b1;
        a_s[sel]         = a;
        b_s[sel]         = b;
        out_ready_s[sel] = (delay == 0);
        @(posedge clk);
        for (int c = 1; c < exp_lat; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (hold) begin
                    a_s[sel] = na;
                    b_s[sel] = nb;
                end else begin
                    in_valid_s[sel] = 1'b0;
                    a_s[sel]        = 8'($urandom);
                    b_s[sel]        = 8'($urandom);
                end
            end
            check("slice_a", sel, 32'(slice_a_o[sel]), 32'((a >> (2 * (c - 1))) & 8'h3));
            check("slice_b", sel, 32'(slice_b_o[sel]), 32'((b >> (2 * (c - 1))) & 8'h3));
            check("run_out_valid", sel, 32'(out_valid_o[sel]), 32'd0);
            check("run_in_ready", sel, 32'(in_ready_o[sel]), 32'd0);
            check("run_busy", sel, 32'(busy_o[sel]), 32'd1);
        end
        @(negedge clk);
        check("done_out_valid", sel, 32'(out_valid_o[sel]), 32'd1);
        check("done_out_eq", sel, 32'(out_eq_o[sel]), 32'(exp_eq));
        check("done_idx", sel, 32'(idx_o[sel]), 32'(exp_idx));
        check("done_slice_a", sel, 32'(slice_a_o[sel]), 32'd0);
        check("done_in_ready", sel, 32'(in_ready_o[sel]), 32'd0);
        for (int d = 0; d < delay; d++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_out_valid", sel, 32'(out_valid_o[sel]), 32'd1);
            check("hold_out_eq", sel, 32'(out_eq_o[sel]), 32'(exp_eq));
            check("hold_idx", sel, 32'(idx_o[sel]), 32'(exp_idx));
            check("hold_in_ready", sel, 32'(in_ready_o[sel]), 32'd0);
        end
        out_ready_s[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_out_valid", sel, 32'(out_valid_o[sel]), 32'd0);
        check("post_in_ready", sel, 32'(in_ready_o[sel]), 32'd1);
        check("post_busy", sel, 32'(busy_o[sel]), 32'd0);
    endtask

    typedef struct {
        int         sel;
        logic [7:0] a;
        logic [7:0] b;
        logic       eq;
        logic [1:0] idx;
        int         lat;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic       m_eq;
        logic [1:0] m_idx;
        int         m_lat;
        logic [7:0] ra;
        logic [7:0] rb;
        int         rsel;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{1, 8'hA5, 8'hA5, 1'b1, 2'd0, 5};
        vecs[1] = '{1, 8'hA5, 8'hA4, 1'b0, 2'd0, 2};
        vecs[2] = '{1, 8'h00, 8'hC0, 1'b0, 2'd3, 5};
        vecs[3] = '{0, 8'h0F, 8'h03, 1'b0, 2'd1, 5};
        vecs[4] = '{0, 8'hA5, 8'hA4, 1'b0, 2'd0, 5};
        vecs[5] = '{1, 8'h0F, 8'h03, 1'b0, 2'd1, 3};
        vecs[6] = '{0, 8'hFF, 8'hFF, 1'b1, 2'd0, 5};
        vecs[7] = '{1, 8'h3C, 8'h3D, 1'b0, 2'd0, 2};
        vecs[8] = '{1, 8'h12, 8'h52, 1'b0, 2'd3, 5};

        // Reset with in_valid asserted: request must be ignored.
        reset_s     = 2'b11;
        in_valid_s  = 2'b11;
        out_ready_s = 2'b00;
        for (int s = 0; s < 2; s++) begin
            a_s[s] = 8'h5A;
            b_s[s] = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_in_ready", s, 32'(in_ready_o[s]), 32'd1);
            check("rst_busy", s, 32'(busy_o[s]), 32'd0);
            check("rst_out_valid", s, 32'(out_valid_o[s]), 32'd0);
            check("rst_out_eq", s, 32'(out_eq_o[s]), 32'd0);
            check("rst_idx", s, 32'(idx_o[s]), 32'd0);
            check("rst_slice_a", s, 32'(slice_a_o[s]), 32'd0);
        end
        reset_s    = 2'b00;
        in_valid_s = 2'b00;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].sel, vecs[i].a, vecs[i].b, 0, 1'b0, 8'h00, 8'h00,
                    vecs[i].eq, vecs[i].idx, vecs[i].lat);
        end

        // Held result with out_ready low and a queued request waiting.
        run_txn(1, 8'hA5, 8'hA5, 3, 1'b1, 8'h3C, 8'h1C, 1'b1, 2'd0, 5);
        run_txn(1, 8'h3C, 8'h1C, 0, 1'b0, 8'h00, 8'h00, 1'b0, 2'd2, 4);

        // Reset in cycle 2 of a transaction, with in_valid asserted alongside.
        in_valid_s[1]  = 1'b1;
        a_s[1]         = 8'hA5;
        b_s[1]         = 8'hA5;
        out_ready_s[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_s[1] = 1'b0;
        check("rst_run_slice_a", 1, 32'(slice_a_o[1]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset_s[1]    = 1'b1;
        in_valid_s[1] = 1'b1;
        a_s[1]        = 8'h00;
        b_s[1]        = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        reset_s[1]    = 1'b0;
        in_valid_s[1] = 1'b0;
        check("midrst_in_ready", 1, 32'(in_ready_o[1]), 32'd1);
        check("midrst_out_valid", 1, 32'(out_valid_o[1]), 32'd0);
        check("midrst_slice_a", 1, 32'(slice_a_o[1]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_still_idle", 1, 32'(busy_o[1]), 32'd0);
        run_txn(1, 8'hC3, 8'hC3, 0, 1'b0, 8'h00, 8'h00, 1'b1, 2'd0, 5);

        // Reset while a result is held in DONE: no result survives.
        in_valid_s[0]  = 1'b1;
        a_s[0]         = 8'h01;
        b_s[0]         = 8'h02;
        out_ready_s[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid_s[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("done_before_rst", 0, 32'(out_valid_o[0]), 32'd1);
        reset_s[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_s[0] = 1'b0;
        check("done_rst_out_valid", 0, 32'(out_valid_o[0]), 32'd0);
        check("done_rst_in_ready", 0, 32'(in_ready_o[0]), 32'd1);
        out_ready_s[0] = 1'b1;

        // Randomized transactions against the reference model.
        for (int i = 0; i < 60; i++) begin
            rsel = int'($urandom_range(0, 1));
            ra   = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = ra;
                1:       rb = ra ^ (8'd1 << $urandom_range(0, 7));
                default: rb = 8'($urandom);
            endcase
            model(rsel, ra, rb, m_eq, m_idx, m_lat);
            run_txn(rsel, ra, rb, int'($urandom_range(0, 2)), 1'b0, 8'h00, 8'h00,
                    m_eq, m_idx, m_lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
